peripheral_arbiter_wb: RTL and testbench
========================================

PERIPHERAL_ARBITER_WB -- requirements
Module: peripheral_arbiter_wb

Interface
REQ-001 SHALL have parameters: AW, default 32, address width; DW, default 32, data width; NUM_MASTERS, default 3, requester count; TIMEOUT, default 255, slave-response timeout in cycles.
REQ-002 SHALL have port wb_clk_i  in  1  sole clock; all logic rising-edge.
REQ-003 SHALL have port wb_rst_i  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports wbm_adr_i/wbm_dat_i/wbm_sel_i/wbm_we_i/wbm_cyc_i/wbm_stb_i/wbm_cti_i/wbm_bte_i  in  NUM_MASTERS x (AW/DW/4/1/1/1/3/2), packed, master 0 in LSBs  master requests.
REQ-005 SHALL have ports wbm_dat_o  out  DW  slave read data broadcast to all masters; wbm_ack_o/wbm_err_o/wbm_rty_o  out  NUM_MASTERS  per-master responses.
REQ-006 SHALL have ports wbs_adr_o/wbs_dat_o/wbs_sel_o/wbs_we_o/wbs_cyc_o/wbs_stb_o/wbs_cti_o/wbs_bte_o  out  AW/DW/4/1/1/1/3/2  shared slave bus.
REQ-007 SHALL have ports wbs_dat_i/wbs_ack_i/wbs_err_i/wbs_rty_i  in  DW/1/1/1  slave responses.
REQ-008 SHALL have port grant_o  out  NUM_MASTERS  one-hot current owner, zero when idle.

Function
REQ-009 SHALL implement FSM IDLE -> OWNED -> IDLE; one owner at most.
REQ-010 In IDLE with any wbm_cyc_i high, SHALL pick owner round-robin starting at last_owner+1 (mod NUM_MASTERS), register grant; OWNED next cycle (1-cycle arbitration latency).
REQ-011 In OWNED, wbs_* outputs SHALL equal owner's wbm_* inputs combinationally; in IDLE, wbs_cyc_o=wbs_stb_o=wbs_we_o=0, other wbs_* = 0.
REQ-012 wbs_ack_i/err_i/rty_i SHALL route only to owner bit; non-owners receive 0 on ack/err/rty.
REQ-013 Ownership SHALL persist across burst beats (cti 3'b010) and back-to-back single transfers while owner's cyc stays high.
REQ-014 Owner cyc low in OWNED SHALL return FSM to IDLE next cycle, update last_owner; no re-grant in that cycle (1 dead cycle between owners).
REQ-015 Simultaneous requests SHALL resolve purely by round-robin; a continuously requesting master SHALL be granted within NUM_MASTERS ownership periods.
REQ-016 Requests from non-owners SHALL be ignored (stalled, no response) until arbitration.

Reset
REQ-017 On wb_rst_i high, immediately: FSM=IDLE, grant_o=0, last_owner=NUM_MASTERS-1 (master 0 wins first), timeout counter=0, all wbs_* and wbm_ack/err/rty outputs 0.
REQ-018 Reset mid-transfer SHALL abort ownership with no response to the aborted master.

Configuration
REQ-019 With PERIPHERAL_ARBITER_WB_TIMEOUT_EN defined: counter increments each OWNED cycle with owner stb high and no ack/err/rty; at count==TIMEOUT SHALL assert owner wbm_err_o for one cycle, force wbs_cyc_o/wbs_stb_o low that cycle, clear counter; counter clears on any slave response or leaving OWNED.
REQ-020 Without PERIPHERAL_ARBITER_WB_TIMEOUT_EN: no counter logic; only slave err passes through.

Structure
REQ-021 Shared package peripheral_arbiter_wb_pkg SHALL hold the FSM state enum and CTI constants (CLASSIC, INCR, END).
REQ-022 Round-robin selection SHALL be a sub-module peripheral_arbiter_rr (request vector, last_owner -> one-hot grant), purely combinational.

Verification
REQ-023 Single master 1 read adr 0x00000100 -> grant_o=3'b010 one cycle after cyc; slave sees adr 0x100; ack only on wbm_ack_o[1].
REQ-024 All three assert cyc same cycle after reset -> grants in order 0,1,2, one dead cycle between each.
REQ-025 Master 0 4-beat INCR burst (cti 010,010,010,111) while master 2 requests -> master 2 granted only after master 0 drops cyc; 4 acks to master 0, none to master 2.
REQ-026 Reset asserted mid-burst of master 1 -> grant_o=0 and wbs_cyc_o=0 immediately; after release master 0 wins first.
REQ-027 TIMEOUT=8, macro defined, slave never acks -> wbm_err_o of owner pulses exactly 8 cycles after stb; macro undefined -> owner stalls indefinitely, no err.

Source files
------------

// File: rtl/peripheral_arbiter_wb_pkg.sv
// Shared types and constants for the Wishbone peripheral arbiter.
package peripheral_arbiter_wb_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } arb_state_e;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_END     = 3'b111;

    // Index width for a requester count, never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/peripheral_arbiter_rr.sv
// Combinational round-robin picker: first requester after last_i wins.
module peripheral_arbiter_rr
    import peripheral_arbiter_wb_pkg::*;
#(
    parameter int unsigned NUM_MASTERS = 3,
    parameter int unsigned IW          = idx_width(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] req_i,
    input  logic [IW-1:0]          last_i,
    output logic [NUM_MASTERS-1:0] grant_o,
    output logic [IW-1:0]          idx_o
);

    logic        found;
    int unsigned cand;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        cand    = 0;
        for (int unsigned i = 1; i <= NUM_MASTERS; i++) begin
            cand = (int'(last_i) + i) % NUM_MASTERS;
            if (!found && req_i[IW'(cand)]) begin
                found                = 1'b1;
                grant_o[IW'(cand)]   = 1'b1;
                idx_o                = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/peripheral_arbiter_wb.sv
// Wishbone N:1 arbiter with round-robin ownership and one dead cycle between owners.
// Optional slave-response timeout enabled by PERIPHERAL_ARBITER_WB_TIMEOUT_EN.
module peripheral_arbiter_wb
    import peripheral_arbiter_wb_pkg::*;
#(
    parameter int unsigned AW          = 32,
    parameter int unsigned DW          = 32,
    parameter int unsigned NUM_MASTERS = 3,
    parameter int unsigned TIMEOUT     = 255
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_i,
    input  logic [NUM_MASTERS*AW-1:0] wbm_adr_i,
    input  logic [NUM_MASTERS*DW-1:0] wbm_dat_i,
    input  logic [NUM_MASTERS*4-1:0]  wbm_sel_i,
    input  logic [NUM_MASTERS-1:0]    wbm_we_i,
    input  logic [NUM_MASTERS-1:0]    wbm_cyc_i,
    input  logic [NUM_MASTERS-1:0]    wbm_stb_i,
    input  logic [NUM_MASTERS*3-1:0]  wbm_cti_i,
    input  logic [NUM_MASTERS*2-1:0]  wbm_bte_i,
    output logic [DW-1:0]             wbm_dat_o,
    output logic [NUM_MASTERS-1:0]    wbm_ack_o,
    output logic [NUM_MASTERS-1:0]    wbm_err_o,
    output logic [NUM_MASTERS-1:0]    wbm_rty_o,
    output logic [AW-1:0]             wbs_adr_o,
    output logic [DW-1:0]             wbs_dat_o,
    output logic [3:0]                wbs_sel_o,
    output logic                      wbs_we_o,
    output logic                      wbs_cyc_o,
    output logic                      wbs_stb_o,
    output logic [2:0]                wbs_cti_o,
    output logic [1:0]                wbs_bte_o,
    input  logic [DW-1:0]             wbs_dat_i,
    input  logic                      wbs_ack_i,
    input  logic                      wbs_err_i,
    input  logic                      wbs_rty_i,
    output logic [NUM_MASTERS-1:0]    grant_o
);

    localparam int unsigned IW = idx_width(NUM_MASTERS);

    arb_state_e             state_q, state_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [IW-1:0]          owner_q, owner_d;
    logic [IW-1:0]          last_q, last_d;

    logic [NUM_MASTERS-1:0] rr_grant;
    logic [IW-1:0]          rr_idx;
    logic                   owned;
    logic                   owner_cyc;
    logic                   owner_stb;
    logic                   slv_resp;
    logic                   to_fire_c;

    peripheral_arbiter_rr #(
        .NUM_MASTERS (NUM_MASTERS),
        .IW          (IW)
    ) u_rr (
        .req_i   (wbm_cyc_i),
        .last_i  (last_q),
        .grant_o (rr_grant),
        .idx_o   (rr_idx)
    );

    assign owned     = (state_q == ST_OWNED);
    assign owner_cyc = wbm_cyc_i[owner_q];
    assign owner_stb = wbm_stb_i[owner_q];
    assign slv_resp  = wbs_ack_i | wbs_err_i | wbs_rty_i;

`ifdef PERIPHERAL_ARBITER_WB_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] to_cnt_q, to_cnt_d;

    // Counts unanswered strobe cycles of the owner; wraps to zero when it fires.
    always_comb begin
        to_cnt_d  = '0;
        to_fire_c = 1'b0;
        if (owned && owner_cyc && owner_stb && !slv_resp) begin
            if (to_cnt_q == CW'(TIMEOUT)) begin
                to_fire_c = 1'b1;
            end else begin
                to_cnt_d = to_cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`else
    assign to_fire_c = 1'b0;
`endif

    // Ownership FSM: arbitrate in IDLE, hold until the owner drops cyc.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        owner_d = owner_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                if (|wbm_cyc_i) begin
                    state_d = ST_OWNED;
                    grant_d = rr_grant;
                    owner_d = rr_idx;
                end
            end
            ST_OWNED: begin
                if (!owner_cyc) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    last_d  = owner_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            owner_q <= '0;
            last_q  <= IW'(NUM_MASTERS - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            last_q  <= last_d;
        end
    end

    // Slave bus mirrors the owner; all-zero when nobody owns it.
    always_comb begin
        wbs_adr_o = '0;
        wbs_dat_o = '0;
        wbs_sel_o = '0;
        wbs_we_o  = 1'b0;
        wbs_cyc_o = 1'b0;
        wbs_stb_o = 1'b0;
        wbs_cti_o = '0;
        wbs_bte_o = '0;
        if (owned) begin
            wbs_adr_o = wbm_adr_i[int'(owner_q)*AW +: AW];
            wbs_dat_o = wbm_dat_i[int'(owner_q)*DW +: DW];
            wbs_sel_o = wbm_sel_i[int'(owner_q)*4 +: 4];
            wbs_we_o  = wbm_we_i[owner_q];
            wbs_cyc_o = owner_cyc & ~to_fire_c;
            wbs_stb_o = owner_stb & ~to_fire_c;
            wbs_cti_o = wbm_cti_i[int'(owner_q)*3 +: 3];
            wbs_bte_o = wbm_bte_i[int'(owner_q)*2 +: 2];
        end
    end

    assign wbm_dat_o = wbs_dat_i;
    assign wbm_ack_o = grant_q & {NUM_MASTERS{wbs_ack_i}};
    assign wbm_err_o = grant_q & {NUM_MASTERS{wbs_err_i | to_fire_c}};
    assign wbm_rty_o = grant_q & {NUM_MASTERS{wbs_rty_i}};
    assign grant_o   = grant_q;

endmodule

// File: tb/tb_peripheral_arbiter_wb.sv
// Scoreboard bench for peripheral_arbiter_wb: directed transfers, grant/response monitor.
module tb_peripheral_arbiter_wb;
    import peripheral_arbiter_wb_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NM = 3;

    logic clk;
    logic rst;

    logic [NM*AW-1:0] wbm_adr;
    logic [NM*DW-1:0] wbm_dat;
    logic [NM*4-1:0]  wbm_sel;
    logic [NM-1:0]    wbm_we, wbm_cyc, wbm_stb;
    logic [NM*3-1:0]  wbm_cti;
    logic [NM*2-1:0]  wbm_bte;
    logic [DW-1:0]    wbm_dat_o;
    logic [NM-1:0]    wbm_ack_o, wbm_err_o, wbm_rty_o;
    logic [AW-1:0]    wbs_adr_o;
    logic [DW-1:0]    wbs_dat_o;
    logic [3:0]       wbs_sel_o;
    logic             wbs_we_o, wbs_cyc_o, wbs_stb_o;
    logic [2:0]       wbs_cti_o;
    logic [1:0]       wbs_bte_o;
    logic [DW-1:0]    s_dat;
    logic             s_ack;
    logic [NM-1:0]    grant_o;

    logic [AW-1:0] m_adr [NM];
    logic [DW-1:0] m_dat [NM];
    logic [2:0]    m_cti [NM];
    logic          m_we  [NM];
    logic          m_cyc [NM];
    logic          m_stb [NM];
    logic [NM-1:0] abort;
    logic          slave_en;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [2:0]  ack;
        logic [2:0]  err;
        logic [31:0] adr;
        logic [2:0]  cti;
        logic        we;
    } resp_t;

    logic [2:0] exp_grant_q [$];
    resp_t      exp_resp_q  [$];

    peripheral_arbiter_wb #(
        .AW (AW), .DW (DW), .NUM_MASTERS (NM), .TIMEOUT (8)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .wbm_adr_i (wbm_adr),
        .wbm_dat_i (wbm_dat),
        .wbm_sel_i (wbm_sel),
        .wbm_we_i  (wbm_we),
        .wbm_cyc_i (wbm_cyc),
        .wbm_stb_i (wbm_stb),
        .wbm_cti_i (wbm_cti),
        .wbm_bte_i (wbm_bte),
        .wbm_dat_o (wbm_dat_o),
        .wbm_ack_o (wbm_ack_o),
        .wbm_err_o (wbm_err_o),
        .wbm_rty_o (wbm_rty_o),
        .wbs_adr_o (wbs_adr_o),
        .wbs_dat_o (wbs_dat_o),
        .wbs_sel_o (wbs_sel_o),
        .wbs_we_o  (wbs_we_o),
        .wbs_cyc_o (wbs_cyc_o),
        .wbs_stb_o (wbs_stb_o),
        .wbs_cti_o (wbs_cti_o),
        .wbs_bte_o (wbs_bte_o),
        .wbs_dat_i (s_dat),
        .wbs_ack_i (s_ack),
        .wbs_err_i (1'b0),
        .wbs_rty_i (1'b0),
        .grant_o   (grant_o)
    );

    always_comb begin
        for (int m = 0; m < NM; m++) begin
            wbm_adr[m*AW +: AW] = m_adr[m];
            wbm_dat[m*DW +: DW] = m_dat[m];
            wbm_sel[m*4 +: 4]   = m_cyc[m] ? 4'hF : 4'h0;
            wbm_we[m]           = m_we[m];
            wbm_cyc[m]          = m_cyc[m];
            wbm_stb[m]          = m_stb[m];
            wbm_cti[m*3 +: 3]   = m_cti[m];
            wbm_bte[m*2 +: 2]   = 2'b00;
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_resp(input logic [2:0] ack, input logic [2:0] err,
                             input logic [31:0] adr, input logic [2:0] cti, input logic we);
        resp_t r;
        r.ack = ack; r.err = err; r.adr = adr; r.cti = cti; r.we = we;
        exp_resp_q.push_back(r);
    endtask

    function automatic logic [2:0] cti_for(input int b, input int beats, input logic burst);
        if (!burst) return CTI_CLASSIC;
        return (b == beats - 1) ? CTI_END : CTI_INCR;
    endfunction

    // One master transaction: holds cyc/stb until every beat is terminated.
    task automatic master_xfer(input int m, input logic [31:0] adr, input logic we,
                               input int beats, input logic burst);
        int   b     = 0;
        int   guard = 0;
        logic got;
        @(posedge clk); #1;
        m_cyc[m] = 1'b1; m_stb[m] = 1'b1; m_we[m] = we;
        m_adr[m] = adr;  m_dat[m] = adr ^ 32'hA5A5_0000;
        m_cti[m] = cti_for(0, beats, burst);
        while (b < beats && !abort[m]) begin
            @(negedge clk);
            got = wbm_ack_o[m] | wbm_err_o[m] | wbm_rty_o[m];
            @(posedge clk); #1;
            if (got) begin
                b++;
                m_adr[m] = adr + 32'(4 * b);
                m_cti[m] = cti_for(b, beats, burst);
            end
            guard++;
            if (guard > 300) begin
                chk($sformatf("master%0d_timeout", m), 32'(b), 32'(beats));
                break;
            end
        end
        m_cyc[m] = 1'b0; m_stb[m] = 1'b0; m_we[m] = 1'b0;
        m_adr[m] = '0;   m_cti[m] = CTI_CLASSIC;
    endtask

    // Slave with one wait state per beat; read data tags the address.
    initial begin
        s_ack = 1'b0;
        s_dat = '0;
        forever begin
            @(posedge clk); #2;
            s_ack = slave_en && wbs_cyc_o && wbs_stb_o && !s_ack;
            s_dat = {16'hD00D, wbs_adr_o[15:0]};
        end
    end

    // Monitor: pops expected grants and responses as the DUT presents them.
    initial begin
        logic [2:0] prev_grant;
        resp_t      e;
        prev_grant = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_grant = '0;
            end else begin
                if (grant_o != prev_grant && grant_o != 3'b000) begin
                    chk("dead_cycle_before_grant", 32'(prev_grant), 32'd0);
                    if (exp_grant_q.size() == 0) begin
                        chk("unexpected_grant", 32'(grant_o), 32'd0);
                    end else begin
                        chk("grant_order", 32'(grant_o), 32'(exp_grant_q.pop_front()));
                    end
                end
                prev_grant = grant_o;
                if (|{wbm_ack_o, wbm_err_o, wbm_rty_o}) begin
                    if (exp_resp_q.size() == 0) begin
                        chk("unexpected_resp", 32'({wbm_ack_o, wbm_err_o, wbm_rty_o}), 32'd0);
                    end else begin
                        e = exp_resp_q.pop_front();
                        chk("resp_ack", 32'(wbm_ack_o), 32'(e.ack));
                        chk("resp_err", 32'(wbm_err_o), 32'(e.err));
                        chk("resp_rty", 32'(wbm_rty_o), 32'd0);
                        chk("slave_adr", wbs_adr_o, e.adr);
                        chk("slave_cti", 32'(wbs_cti_o), 32'(e.cti));
                        chk("slave_we", 32'(wbs_we_o), 32'(e.we));
                        if (e.ack != 3'b000)
                            chk("read_data", wbm_dat_o, {16'hD00D, e.adr[15:0]});
                    end
                end
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #3;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int g;
        int n;
        rst      = 1'b1;
        slave_en = 1'b1;
        abort    = '0;
        for (int m = 0; m < NM; m++) begin
            m_adr[m] = '0; m_dat[m] = '0; m_cti[m] = '0;
            m_we[m]  = 1'b0; m_cyc[m] = 1'b0; m_stb[m] = 1'b0;
        end

        repeat (2) @(posedge clk); #1;
        chk("reset_grant", 32'(grant_o), 32'd0);
        chk("reset_wbs_cyc", 32'(wbs_cyc_o), 32'd0);
        chk("reset_wbs_stb", 32'(wbs_stb_o), 32'd0);
        chk("reset_wbs_we", 32'(wbs_we_o), 32'd0);
        chk("reset_wbs_adr", wbs_adr_o, 32'd0);
        chk("reset_resp", 32'({wbm_ack_o, wbm_err_o, wbm_rty_o}), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single read by master 1, one-cycle arbitration latency.
        exp_grant_q.push_back(3'b010);
        push_resp(3'b010, 3'b000, 32'h0000_0100, CTI_CLASSIC, 1'b0);
        fork
            master_xfer(1, 32'h0000_0100, 1'b0, 1, 1'b0);
            begin
                @(negedge clk);
                chk("grant_before_latency", 32'(grant_o), 32'd0);
                @(negedge clk);
                chk("grant_after_latency", 32'(grant_o), 32'b010);
                chk("slave_adr_m1", wbs_adr_o, 32'h0000_0100);
            end
        join
        repeat (3) @(negedge clk);

        // Three simultaneous requesters after reset: 0, 1, 2.
        do_reset();
        exp_grant_q.push_back(3'b001);
        exp_grant_q.push_back(3'b010);
        exp_grant_q.push_back(3'b100);
        push_resp(3'b001, 3'b000, 32'h0000_1000, CTI_CLASSIC, 1'b0);
        push_resp(3'b010, 3'b000, 32'h0000_2000, CTI_CLASSIC, 1'b1);
        push_resp(3'b100, 3'b000, 32'h0000_3000, CTI_CLASSIC, 1'b0);
        fork
            master_xfer(0, 32'h0000_1000, 1'b0, 1, 1'b0);
            master_xfer(1, 32'h0000_2000, 1'b1, 1, 1'b0);
            master_xfer(2, 32'h0000_3000, 1'b0, 1, 1'b0);
        join
        repeat (3) @(negedge clk);

        // Master 0 incrementing burst holds the bus against master 2.
        do_reset();
        exp_grant_q.push_back(3'b001);
        exp_grant_q.push_back(3'b100);
        push_resp(3'b001, 3'b000, 32'h0000_4000, CTI_INCR, 1'b0);
        push_resp(3'b001, 3'b000, 32'h0000_4004, CTI_INCR, 1'b0);
        push_resp(3'b001, 3'b000, 32'h0000_4008, CTI_INCR, 1'b0);
        push_resp(3'b001, 3'b000, 32'h0000_400C, CTI_END, 1'b0);
        push_resp(3'b100, 3'b000, 32'h0000_5000, CTI_CLASSIC, 1'b0);
        fork
            master_xfer(0, 32'h0000_4000, 1'b0, 4, 1'b1);
            master_xfer(2, 32'h0000_5000, 1'b0, 1, 1'b0);
        join
        repeat (3) @(negedge clk);

        // Reset in the middle of a master 1 burst.
        do_reset();
        exp_grant_q.push_back(3'b010);
        push_resp(3'b010, 3'b000, 32'h0000_6000, CTI_INCR, 1'b0);
        fork
            master_xfer(1, 32'h0000_6000, 1'b0, 4, 1'b1);
            begin
                g = 0;
                do begin
                    @(negedge clk);
                    g++;
                end while (!wbm_ack_o[1] && g < 20);
                chk("burst_first_ack", 32'(wbm_ack_o[1]), 32'd1);
                @(posedge clk); #3;
                rst = 1'b1;
                #1;
                chk("midburst_rst_grant", 32'(grant_o), 32'd0);
                chk("midburst_rst_cyc", 32'(wbs_cyc_o), 32'd0);
                chk("midburst_rst_stb", 32'(wbs_stb_o), 32'd0);
                chk("midburst_rst_resp", 32'({wbm_ack_o, wbm_err_o, wbm_rty_o}), 32'd0);
                abort[1] = 1'b1;
                repeat (3) @(posedge clk);
                #3 rst = 1'b0;
                abort = '0;
            end
        join
        @(negedge clk);
        exp_grant_q.push_back(3'b001);
        exp_grant_q.push_back(3'b010);
        push_resp(3'b001, 3'b000, 32'h0000_7000, CTI_CLASSIC, 1'b0);
        push_resp(3'b010, 3'b000, 32'h0000_7100, CTI_CLASSIC, 1'b0);
        fork
            master_xfer(0, 32'h0000_7000, 1'b0, 1, 1'b0);
            master_xfer(1, 32'h0000_7100, 1'b0, 1, 1'b0);
        join
        repeat (3) @(negedge clk);

        // Slave never answers.
        do_reset();
        slave_en = 1'b0;
        exp_grant_q.push_back(3'b001);
`ifdef PERIPHERAL_ARBITER_WB_TIMEOUT_EN
        push_resp(3'b000, 3'b001, 32'h0000_8000, CTI_CLASSIC, 1'b1);
        fork
            master_xfer(0, 32'h0000_8000, 1'b1, 1, 1'b0);
            begin
                g = 0;
                do begin
                    @(negedge clk);
                    g++;
                end while (grant_o != 3'b001 && g < 10);
                n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (!wbm_err_o[0] && n < 30);
                chk("timeout_latency", 32'(n), 32'd8);
                chk("timeout_cyc_forced_low", 32'(wbs_cyc_o), 32'd0);
            end
        join
`else
        fork
            master_xfer(0, 32'h0000_8000, 1'b1, 1, 1'b0);
            begin
                repeat (40) @(negedge clk);
                chk("stall_no_err", 32'(wbm_err_o), 32'd0);
                chk("stall_grant_held", 32'(grant_o), 32'b001);
                chk("stall_stb_held", 32'(wbs_stb_o), 32'd1);
                abort[0] = 1'b1;
            end
        join
        abort = '0;
`endif
        slave_en = 1'b1;
        repeat (4) @(negedge clk);

        chk("grant_queue_drained", 32'(exp_grant_q.size()), 32'd0);
        chk("resp_queue_drained", 32'(exp_resp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
